// File: rtl/dds_sweep_ctrl_pkg.sv
// dds_sweep_ctrl_pkg: mode and state encodings shared by the sweep controller.
package dds_sweep_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_SAW    = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN_UP = 2'b01,
    RUN_DN = 2'b10
  } state_e;
endpackage

// File: rtl/dds_sweep_ctrl_dwell_counter.sv
// dwell_counter: per-step tick counter, load has priority over decrement.
module dwell_counter #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [DW-1:0] load_val,
  output logic          zero
);
  logic [DW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : dec ? cnt_q - DW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear chirp generator driving the DDS phase increment.
module dds_sweep_ctrl import dds_sweep_ctrl_pkg::*; #(
  parameter int M  = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [M-1:0]  p_start,
  input  logic [M-1:0]  p_stop,
  input  logic [M-1:0]  p_step,
  input  logic [DW-1:0] dwell,
  input  logic          tick,
  output logic [M-1:0]  P,
  output logic          val_out,
  output logic          busy,
  output logic          done
);
  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [M-1:0]  start_q, start_d, stop_q, stop_d, step_q, step_d, p_q, p_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          val_q, val_d, done_q, done_d;
  logic          go, step_evt, cnt_zero, at_top, at_bot, is_single, tri_turn;
  logic [M:0]    up_sum;
  logic [M-1:0]  up_val, dn_val;
  assign busy      = state_q != IDLE;
  assign go        = start && !abort && state_q == IDLE;
  assign step_evt  = tick && busy && cnt_zero && !abort;
  assign is_single = !(mode_q == MODE_SAW || mode_q == MODE_TRI);
  assign tri_turn  = mode_q == MODE_TRI && step_q != '0;
  assign at_top    = p_q == stop_q || step_q == '0;
  assign at_bot    = p_q == start_q;
  assign up_sum    = {1'b0, p_q} + {1'b0, step_q};
  assign up_val    = up_sum >= {1'b0, stop_q} ? stop_q : up_sum[M-1:0];
  // At the top of a triangle p_q equals stop_q, so dn_val doubles as the turnaround value.
  assign dn_val    = step_q >= p_q - start_q ? start_q : p_q - step_q;
  dwell_counter #(.DW(DW)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (go || step_evt),
    .dec      (tick && busy && !cnt_zero),
    .load_val (go ? (dwell == '0 ? DW'(0) : dwell - DW'(1)) : dwell_q - DW'(1)),
    .zero     (cnt_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else if (go) state_d = RUN_UP;
    else if (step_evt && state_q == RUN_UP && at_top)
      state_d = is_single ? IDLE : tri_turn ? RUN_DN : RUN_UP;
    else if (step_evt && state_q == RUN_DN && at_bot) state_d = RUN_UP;
  end
  always_comb begin
    mode_d  = go ? mode_e'(mode) : mode_q;
    start_d = go ? (p_stop < p_start ? p_stop : p_start) : start_q;
    stop_d  = go ? (p_stop < p_start ? p_start : p_stop) : stop_q;
    step_d  = go ? p_step : step_q;
    dwell_d = go ? (dwell == '0 ? DW'(1) : dwell) : dwell_q;
    p_d     = go ? start_d : !step_evt ? p_q :
              state_q == RUN_DN ? (at_bot ? up_val : dn_val) :
              !at_top ? up_val : mode_q == MODE_SAW ? start_q : tri_turn ? dn_val : p_q;
    val_d   = tick && busy && !abort;
    done_d  = (abort && busy) || (step_evt && state_q == RUN_UP && at_top && is_single);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q  <= MODE_SINGLE;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      p_q     <= '0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      p_q     <= p_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  assign P       = p_q;
  assign val_out = val_q;
  assign done    = done_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed-vector bench for the DDS sweep controller.
module tb_dds_sweep_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, tick = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] p_start = '0, p_stop = '0, p_step = '0, dwell = '0;
  logic [15:0] P;
  logic        val_out, busy, done;
  int          n_checks = 0, n_fail = 0;
  dds_sweep_ctrl #(.M(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .p_start(p_start), .p_stop(p_stop), .p_step(p_step), .dwell(dwell),
    .tick(tick), .P(P), .val_out(val_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic clk_step;
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input logic [1:0] m, input logic [15:0] a, b, s, d);
    mode = m; p_start = a; p_stop = b; p_step = s; dwell = d; start = 1'b1;
    clk_step();
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick = 1'b1;
    clk_step();
    clk_step();
    n_checks++; if (P !== 16'd0) begin n_fail++; $display("FAIL reset_P got %0d want 0", P); end
    n_checks++; if ({busy, val_out, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, val_out, done}); end
    rst_n = 1'b1;
    clk_step();
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL idle_tick got %b want 00", {busy, done}); end
  endtask
  task automatic test_single_up;
    logic [15:0] e [8];
    e = '{16'd100, 16'd100, 16'd110, 16'd110, 16'd120, 16'd120, 16'd130, 16'd130};
    tick = 1'b1;
    kick(2'b00, 16'd100, 16'd130, 16'd10, 16'd2);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (P !== e[i]) begin n_fail++; $display("FAIL single_P[%0d] got %0d want %0d", i, P, e[i]); end
      n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL single_bd[%0d] got %b want 10", i, {busy, done}); end
      n_checks++; if (val_out !== (i > 0)) begin n_fail++; $display("FAIL single_val[%0d] got %b want %b", i, val_out, i > 0); end
      clk_step();
    end
    n_checks++; if ({busy, done, P} !== {2'b01, 16'd130}) begin n_fail++; $display("FAIL single_end got b%b d%b P%0d want b0 d1 P130", busy, done, P); end
    clk_step();
    n_checks++; if ({done, P} !== {1'b0, 16'd130}) begin n_fail++; $display("FAIL single_after got d%b P%0d want d0 P130", done, P); end
  endtask
  task automatic test_clamp;
    logic [15:0] e [4];
    e = '{16'd100, 16'd110, 16'd120, 16'd125};
    kick(2'b00, 16'd100, 16'd125, 16'd10, 16'd1);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({busy, done, P} !== {2'b10, e[i]}) begin n_fail++; $display("FAIL clamp[%0d] got b%b d%b P%0d want b1 d0 P%0d", i, busy, done, P, e[i]); end
      clk_step();
    end
    n_checks++; if ({busy, done, P} !== {2'b01, 16'd125}) begin n_fail++; $display("FAIL clamp_end got b%b d%b P%0d want b0 d1 P125", busy, done, P); end
  endtask
  task automatic test_triangle;
    logic [15:0] e [9];
    e = '{16'd0, 16'd10, 16'd20, 16'd10, 16'd0, 16'd10, 16'd20, 16'd10, 16'd0};
    clk_step();
    kick(2'b10, 16'd0, 16'd20, 16'd10, 16'd1);
    for (int i = 0; i < 9; i++) begin
      n_checks++; if ({busy, done, P} !== {2'b10, e[i]}) begin n_fail++; $display("FAIL tri[%0d] got b%b d%b P%0d want b1 d0 P%0d", i, busy, done, P, e[i]); end
      clk_step();
    end
    tick = 1'b0;
    clk_step();
    n_checks++; if ({val_out, P} !== {1'b0, 16'd10}) begin n_fail++; $display("FAIL tri_notick got v%b P%0d want v0 P10", val_out, P); end
    clk_step();
    n_checks++; if ({val_out, P} !== {1'b0, 16'd10}) begin n_fail++; $display("FAIL tri_hold got v%b P%0d want v0 P10", val_out, P); end
    tick = 1'b1;
    clk_step();
    n_checks++; if ({val_out, P} !== {1'b1, 16'd20}) begin n_fail++; $display("FAIL tri_resume got v%b P%0d want v1 P20", val_out, P); end
    abort = 1'b1;
    clk_step();
    abort = 1'b0;
    n_checks++; if ({busy, done, val_out, P} !== {3'b010, 16'd20}) begin n_fail++; $display("FAIL tri_abort got b%b d%b v%b P%0d want b0 d1 v0 P20", busy, done, val_out, P); end
  endtask
  task automatic test_swapped_degenerate;
    logic [15:0] e [4];
    e = '{16'd20, 16'd30, 16'd40, 16'd50};
    clk_step();
    kick(2'b00, 16'd50, 16'd20, 16'd10, 16'd1);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({busy, P} !== {1'b1, e[i]}) begin n_fail++; $display("FAIL swap[%0d] got b%b P%0d want b1 P%0d", i, busy, P, e[i]); end
      clk_step();
    end
    n_checks++; if ({busy, done, P} !== {2'b01, 16'd50}) begin n_fail++; $display("FAIL swap_end got b%b d%b P%0d want b0 d1 P50", busy, done, P); end
    clk_step();
    kick(2'b00, 16'd40, 16'd90, 16'd0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({busy, done, P} !== {2'b10, 16'd40}) begin n_fail++; $display("FAIL stall[%0d] got b%b d%b P%0d want b1 d0 P40", i, busy, done, P); end
      clk_step();
    end
    n_checks++; if ({busy, done, P} !== {2'b01, 16'd40}) begin n_fail++; $display("FAIL stall_end got b%b d%b P%0d want b0 d1 P40", busy, done, P); end
    clk_step();
    kick(2'b01, 16'd60, 16'd60, 16'd5, 16'd1);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({busy, done, P} !== {2'b10, 16'd60}) begin n_fail++; $display("FAIL saw_eq[%0d] got b%b d%b P%0d want b1 d0 P60", i, busy, done, P); end
      clk_step();
    end
    abort = 1'b1;
    clk_step();
    abort = 1'b0;
  endtask
  task automatic test_control;
    clk_step();
    kick(2'b00, 16'd100, 16'd130, 16'd10, 16'd1);
    mode = 2'b01; p_start = 16'd7; p_stop = 16'd9; p_step = 16'd1; dwell = 16'd4; start = 1'b1;
    clk_step();
    start = 1'b0;
    n_checks++; if ({busy, P} !== {1'b1, 16'd110}) begin n_fail++; $display("FAIL busy_start got b%b P%0d want b1 P110", busy, P); end
    clk_step();
    n_checks++; if (P !== 16'd120) begin n_fail++; $display("FAIL busy_start2 got %0d want 120", P); end
    abort = 1'b1; start = 1'b1;
    clk_step();
    abort = 1'b0; start = 1'b0;
    n_checks++; if ({busy, done, val_out, P} !== {3'b010, 16'd120}) begin n_fail++; $display("FAIL abort_start got b%b d%b v%b P%0d want b0 d1 v0 P120", busy, done, val_out, P); end
    clk_step();
    n_checks++; if ({busy, done, P} !== {2'b00, 16'd120}) begin n_fail++; $display("FAIL abort_after got b%b d%b P%0d want b0 d0 P120", busy, done, P); end
    abort = 1'b1; start = 1'b1;
    clk_step();
    abort = 1'b0; start = 1'b0;
    n_checks++; if ({busy, done, P} !== {2'b00, 16'd120}) begin n_fail++; $display("FAIL idle_abort got b%b d%b P%0d want b0 d0 P120", busy, done, P); end
    kick(2'b00, 16'd5, 16'd7, 16'd1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({busy, done, P} !== {2'b10, 16'(5 + i)}) begin n_fail++; $display("FAIL dwell0[%0d] got b%b d%b P%0d want b1 d0 P%0d", i, busy, done, P, 5 + i); end
      clk_step();
    end
    n_checks++; if ({busy, done, P} !== {2'b01, 16'd7}) begin n_fail++; $display("FAIL dwell0_end got b%b d%b P%0d want b0 d1 P7", busy, done, P); end
  endtask
  task automatic test_async_reset;
    clk_step();
    kick(2'b01, 16'd100, 16'd200, 16'd10, 16'd1);
    clk_step();
    clk_step();
    clk_step();
    n_checks++; if (P !== 16'd130) begin n_fail++; $display("FAIL pre_reset got %0d want 130", P); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, val_out, done, P} !== {3'b000, 16'd0}) begin n_fail++; $display("FAIL async_reset got b%b v%b d%b P%0d want all 0", busy, val_out, done, P); end
    rst_n = 1'b1;
    clk_step();
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL post_reset got b%b d%b want b0 d0", busy, done); end
    kick(2'b00, 16'd10, 16'd30, 16'd10, 16'd1);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({busy, P} !== {1'b1, 16'(10 + 10 * i)}) begin n_fail++; $display("FAIL rerun[%0d] got b%b P%0d want b1 P%0d", i, busy, P, 10 + 10 * i); end
      clk_step();
    end
    n_checks++; if ({busy, done, P} !== {2'b01, 16'd30}) begin n_fail++; $display("FAIL rerun_end got b%b d%b P%0d want b0 d1 P30", busy, done, P); end
  endtask
  initial begin
    test_reset();
    test_single_up();
    test_clamp();
    test_triangle();
    test_swapped_degenerate();
    test_control();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep controller placed directly upstream of the DDS phase accumulator; drives its phase increment P and valid strobe.
- Produces linear chirps from p_start to p_stop in p_step increments, holding each increment for a programmable number of sample ticks.
- Supports single-shot, repeating sawtooth and triangle (up/down) sweeps, with start/abort control and busy/done status for a host FSM.

Parameters:
- M, 16, phase-increment width; must equal the accumulator width M.
- DW, 16, dwell-counter width (samples per frequency step).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches configuration and begins a sweep when idle.
- abort  in  1  single-cycle pulse; terminates a sweep immediately.
- mode  in  2  00 single, 01 sawtooth repeat, 10 triangle repeat, 11 reserved (treated as single).
- p_start  in  M  first phase increment (unsigned).
- p_stop  in  M  final phase increment (unsigned).
- p_step  in  M  increment added or subtracted per step (unsigned).
- dwell  in  DW  ticks per step; 0 is treated as 1.
- tick  in  1  sample-rate strobe; the sweep advances only on tick.
- P  out  M  phase increment to the accumulator, registered.
- val_out  out  1  registered copy of tick while running; feeds the DDS val_in.
- busy  out  1  high in RUN_UP or RUN_DN.
- done  out  1  one-cycle pulse when a single sweep completes or an abort is taken.

Behaviour:
- Reset: P=0, val_out=0, busy=0, done=0, state=IDLE, dwell counter=0, latched config=0.
- States: IDLE, RUN_UP, RUN_DN.
- IDLE + start:
  - Latch mode, p_start, p_stop, p_step and max(dwell,1).
  - P<=p_start, counter<=dwell_l-1, next state RUN_UP.
  - If p_stop<p_start, swap them internally so the sweep always runs upward from min to max.
- start while busy is ignored. Inputs are sampled only at start; later input changes have no effect.
- RUN_x, tick with counter!=0: counter decrements; P holds.
- RUN_UP, tick with counter==0:
  - Reload counter<=dwell_l-1.
  - nxt = P+p_step, computed in M+1 bits (no wrap). If nxt>=stop_l, P<=stop_l.
  - If P was already equal to stop_l at this tick, the end-of-sweep action below applies instead of stepping.
- End of sweep:
  - single: go to IDLE, done=1 for one cycle, P holds stop_l.
  - sawtooth: P<=start_l, stay in RUN_UP.
  - triangle: go to RUN_DN, P<=max(stop_l-p_step, start_l).
- RUN_DN mirrors RUN_UP: subtract with clamp at start_l. At start_l after a full dwell, go to RUN_UP and step up.
- p_step==0: sweep stalls at start_l. Single mode completes after one dwell (done pulse). Repeat modes hold P indefinitely.
- start_l==stop_l: single mode gives one dwell then done. Triangle and sawtooth hold P.
- val_out<=tick&&busy, so it is aligned with the P value valid on that tick. P changes take effect one cycle after the tick that steps them.
- abort (any state): next cycle state=IDLE, busy=0, val_out=0, P holds, done=1 only if abort occurred while busy.
- abort and start in the same cycle: abort wins and start is dropped.
- rst_n asserted mid-sweep: all outputs return to reset values asynchronously. No done pulse.

Decomposition:
- Shared package: mode encodings (MODE_SINGLE, MODE_SAW, MODE_TRI) and state encodings.
- Sub-module dwell_counter (DW-bit, load/decrement on tick, zero flag).
- Clamped add/sub stays inline in the top module.

Test Plan:
- Single up sweep: M=16, start=100, stop=130, step=10, dwell=2, tick every cycle → P=100,100,110,110,120,120,130,130; done pulses once; busy drops with done.
- Clamp: start=100, stop=125, step=10, dwell=1 → P=100,110,120,125; then done; P never exceeds 125.
- Triangle: start=0, stop=20, step=10, dwell=1 → P=0,10,20,10,0,10,20,…; no done; val_out mirrors tick.
- Swapped/degenerate: start=50, stop=20 → sweep 20..50. p_step=0 single, dwell=3 → P=start for 3 ticks, then done.
- Control corners: start during RUN ignored (P sequence unchanged); abort+start same cycle → IDLE, done=1, P held; dwell=0 behaves as dwell=1.
- Async reset mid-sweep (rst_n low between clock edges) → P=0, busy=0, val_out=0 immediately; a new start after release runs cleanly.
